control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter: CNT_W, default 16, width of retired-instruction counter.
REQ-002 Ports: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Ports: rstn  input  1  asynchronous, active-low reset.
REQ-004 Ports: start  input  1  begin or resume execution; honoured only in IDLE or HALT.
REQ-005 Ports: ir_in  input  8  instruction register contents; [3:0] opcode, [7:4] register field.
REQ-006 Ports: mem_ack  input  1  memory completion; meaningful only while mem_req=1.
REQ-007 Ports: wr_sel  output  4  bus destination code: 0 none, 1-5 R1-R5, 6 AR, 7 AC, 8 IR, 9 PC.
REQ-008 Ports: rd_sel  output  4  bus source code: same codes as wr_sel, plus 10 MEM, 11 ALU.
REQ-009 Ports: mem_req  output  1  memory access request, held until mem_ack.
REQ-010 Ports: mem_we  output  1  write qualifier, valid only with mem_req=1.
REQ-011 Ports: alu_add  output  1  ALU performs AC + bus operand.
REQ-012 Ports: pc_inc  output  1  one-cycle PC increment strobe.
REQ-013 Ports: halted  output  1  high in HALT state.
REQ-014 Ports: err  output  1  sticky illegal-instruction flag.
REQ-015 Ports: instr_cnt  output  CNT_W  retired-instruction count.

Function
REQ-016 States: IDLE, F_AR, F_MEM, DECODE, X_AR, X_MEM, X_REG, HALT; state registered, outputs decoded from state, ir_in and mem_ack.
REQ-017 All outputs 0 in any state/cycle not listed below.
REQ-018 IDLE: start=1 -> F_AR; else stay.
REQ-019 F_AR: rd_sel=9, wr_sel=6; -> F_MEM next cycle.
REQ-020 F_MEM: mem_req=1, mem_we=0; mem_ack=0 stay; mem_ack=1 same cycle rd_sel=10, wr_sel=8, pc_inc=1, -> DECODE.
REQ-021 DECODE (one cycle, no bus activity) by ir_in[3:0]: 0 NOP retire -> F_AR; 1 LOAD/2 STORE -> X_AR; 3 MOV, 4 MOVAC, 5 ADD, 6 JMP -> X_REG; 7 HALT retire -> HALT; 8-15 illegal per REQ-032/033.
REQ-022 X_AR: rd_sel=1, wr_sel=6 (AR <= R1); -> X_MEM.
REQ-023 X_MEM LOAD: mem_req=1, mem_we=0; on mem_ack rd_sel=10, wr_sel=7, retire, -> F_AR.
REQ-024 X_MEM STORE: mem_req=1, mem_we=1, rd_sel=7 whole state; on mem_ack retire, -> F_AR.
REQ-025 X_REG, one cycle, then retire -> F_AR: MOV rd_sel=7, wr_sel=ir_in[7:4]; MOVAC rd_sel=ir_in[7:4], wr_sel=7; ADD rd_sel=11, wr_sel=7, alu_add=1; JMP rd_sel=1, wr_sel=9.
REQ-026 MOV/MOVAC/ADD register field outside 1-5 is illegal; detected in DECODE, not executed.
REQ-027 Retire: instr_cnt += 1 in that cycle, wraps all-ones to 0 without flag.
REQ-028 Fetch-to-retire latency: NOP 3 cycles, ADD 4 cycles, LOAD 5 cycles, each with zero memory wait; each extra mem_ack-low cycle adds one.
REQ-029 HALT: halted=1; start=1 -> F_AR next cycle, err and instr_cnt retained.
REQ-030 start outside IDLE/HALT ignored; mem_ack while mem_req=0 ignored.
REQ-031 ir_in sampled only in DECODE and X_REG/X_MEM; controller does not latch it.

Configuration
REQ-032 Macro ILLEGAL_TRAP_EN defined: illegal instruction sets err=1, not retired, -> HALT.
REQ-033 Macro ILLEGAL_TRAP_EN undefined: illegal instruction executes as NOP (retired, -> F_AR); err tied 0.

Reset
REQ-034 rstn=0 immediately forces IDLE, all outputs 0, err=0, instr_cnt=0, regardless of clk.
REQ-035 Reset during F_MEM/X_MEM drops mem_req asynchronously; a later mem_ack is ignored.
REQ-036 After rstn deasserts, first state change needs start=1 on a rising edge.

Verification
REQ-037 Reset, start pulse, ir_in=0x00, mem_ack same cycle as request -> wr_sel sequence 6,8,0, pc_inc once, instr_cnt=1 three cycles after F_AR.
REQ-038 ir_in=0x01, mem_ack delayed 3 cycles in X_MEM -> mem_req high 4 cycles, mem_we=0, final cycle rd_sel=10 wr_sel=7.
REQ-039 ir_in=0x23 (MOV R2) -> X_REG rd_sel=7, wr_sel=2; ir_in=0x73 -> illegal: with ILLEGAL_TRAP_EN err=1, halted=1, instr_cnt unchanged; without, retired as NOP.
REQ-040 ir_in=0x07 -> halted=1; start ignored in F_MEM, accepted in HALT -> F_AR next cycle.
REQ-041 rstn low mid X_MEM STORE -> mem_req, mem_we 0 before next clk edge; CNT_W=4, 16 NOPs -> instr_cnt wraps to 0.

Source files
------------

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Microcoded-style control unit for a small accumulator CPU.
//                Fetches an instruction over a shared bus (PC -> AR, MEM -> IR),
//                decodes it and issues bus source/destination selects, memory
//                requests and ALU strobes until the instruction retires.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   single clock, rising-edge
//    rstn       in   asynchronous active-low reset
//    start      in   begin/resume execution (IDLE or HALT only)
//    ir_in      in   [3:0] opcode, [7:4] register field
//    mem_ack    in   memory completion, meaningful only while mem_req=1
//    wr_sel     out  bus destination (0 none, 1-5 R1-R5, 6 AR, 7 AC, 8 IR, 9 PC)
//    rd_sel     out  bus source (as wr_sel, plus 10 MEM, 11 ALU)
//    mem_req    out  memory request, held until mem_ack
//    mem_we     out  memory write qualifier
//    alu_add    out  ALU computes AC + bus operand
//    pc_inc     out  one-cycle PC increment strobe
//    halted     out  high in HALT
//    err        out  sticky illegal-instruction flag
//    instr_cnt  out  retired-instruction count (wraps silently)
//  Configuration
//    ILLEGAL_TRAP_EN  defined  : illegal instruction sets err and halts
//                     undefined: illegal instruction executes as NOP, err=0
// ============================================================================
module control_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [7:0]       ir_in,
  input  logic             mem_ack,
  output logic [3:0]       wr_sel,
  output logic [3:0]       rd_sel,
  output logic             mem_req,
  output logic             mem_we,
  output logic             alu_add,
  output logic             pc_inc,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [3:0] c_SEL_NONE = 4'd0;
  localparam logic [3:0] c_SEL_R1   = 4'd1;
  localparam logic [3:0] c_SEL_AR   = 4'd6;
  localparam logic [3:0] c_SEL_AC   = 4'd7;
  localparam logic [3:0] c_SEL_IR   = 4'd8;
  localparam logic [3:0] c_SEL_PC   = 4'd9;
  localparam logic [3:0] c_SEL_MEM  = 4'd10;
  localparam logic [3:0] c_SEL_ALU  = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_F_AR   = 3'd1,
    S_F_MEM  = 3'd2,
    S_DECODE = 3'd3,
    S_X_AR   = 3'd4,
    S_X_MEM  = 3'd5,
    S_X_REG  = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             w_retire;
  logic             w_trap;

  logic [3:0] w_op;
  logic [3:0] w_rf;
  logic       w_rf_ok;
  logic       w_illegal;

  assign w_op    = ir_in[3:0];
  assign w_rf    = ir_in[7:4];
  assign w_rf_ok = (w_rf >= 4'd1) && (w_rf <= 4'd5);
  // Opcodes 8-15 are undefined; register-moving ops need a real register R1-R5.
  // JMP always sources R1, so its register field is don't-care.
  assign w_illegal = w_op[3] |
                     (((w_op == 4'd3) || (w_op == 4'd4) || (w_op == 4'd5)) && !w_rf_ok);

  // Outputs are decoded combinationally from the registered state so that the
  // memory-acknowledge cycle can complete its bus transfer in the same cycle,
  // and so that an asynchronous reset clears them immediately.
  always_comb begin
    state_d  = state_q;
    wr_sel   = c_SEL_NONE;
    rd_sel   = c_SEL_NONE;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    alu_add  = 1'b0;
    pc_inc   = 1'b0;
    halted   = 1'b0;
    w_retire = 1'b0;
    w_trap   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_F_AR;
      end
      S_F_AR: begin
        rd_sel  = c_SEL_PC;
        wr_sel  = c_SEL_AR;
        state_d = S_F_MEM;
      end
      S_F_MEM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          rd_sel  = c_SEL_MEM;
          wr_sel  = c_SEL_IR;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_illegal) begin
`ifdef ILLEGAL_TRAP_EN
          w_trap  = 1'b1;
          state_d = S_HALT;
`else
          w_retire = 1'b1;
          state_d  = S_F_AR;
`endif
        end else begin
          case (w_op)
            4'd1, 4'd2:             state_d = S_X_AR;
            4'd3, 4'd4, 4'd5, 4'd6: state_d = S_X_REG;
            4'd7: begin
              w_retire = 1'b1;
              state_d  = S_HALT;
            end
            default: begin
              w_retire = 1'b1;
              state_d  = S_F_AR;
            end
          endcase
        end
      end
      S_X_AR: begin
        rd_sel  = c_SEL_R1;
        wr_sel  = c_SEL_AR;
        state_d = S_X_MEM;
      end
      S_X_MEM: begin
        mem_req = 1'b1;
        if (w_op == 4'd2) begin
          // STORE drives AC onto the bus for the whole access.
          mem_we = 1'b1;
          rd_sel = c_SEL_AC;
        end else if (mem_ack) begin
          rd_sel = c_SEL_MEM;
          wr_sel = c_SEL_AC;
        end
        if (mem_ack) begin
          w_retire = 1'b1;
          state_d  = S_F_AR;
        end
      end
      S_X_REG: begin
        case (w_op)
          4'd3: begin rd_sel = c_SEL_AC; wr_sel = w_rf; end
          4'd4: begin rd_sel = w_rf; wr_sel = c_SEL_AC; end
          4'd5: begin rd_sel = c_SEL_ALU; wr_sel = c_SEL_AC; alu_add = 1'b1; end
          4'd6: begin rd_sel = c_SEL_R1; wr_sel = c_SEL_PC; end
          default: ;
        endcase
        w_retire = 1'b1;
        state_d  = S_F_AR;
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) state_d = S_F_AR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (w_retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign instr_cnt = cnt_q;

`ifdef ILLEGAL_TRAP_EN
  logic err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (w_trap) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Directed self-checking bench for control_sequencer. Inputs
//                change on the falling edge; outputs are checked shortly after.
//                A second instance with CNT_W=4 shares all inputs and is used
//                for the counter wrap check.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [7:0] ir_in;
  logic       mem_ack;

  logic [3:0]  wr_sel, rd_sel;
  logic        mem_req, mem_we, alu_add, pc_inc, halted, err;
  logic [15:0] instr_cnt;

  logic [3:0] wr_sel4, rd_sel4;
  logic       mem_req4, mem_we4, alu_add4, pc_inc4, halted4, err4;
  logic [3:0] instr_cnt4;

  int n_assert = 0;
  int n_fail   = 0;
  int ecnt     = 0;
  logic exp_err;

  always #5 clk = ~clk;

  control_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .ir_in(ir_in), .mem_ack(mem_ack),
    .wr_sel(wr_sel), .rd_sel(rd_sel), .mem_req(mem_req), .mem_we(mem_we),
    .alu_add(alu_add), .pc_inc(pc_inc), .halted(halted), .err(err),
    .instr_cnt(instr_cnt)
  );

  control_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .start(start), .ir_in(ir_in), .mem_ack(mem_ack),
    .wr_sel(wr_sel4), .rd_sel(rd_sel4), .mem_req(mem_req4), .mem_we(mem_we4),
    .alu_add(alu_add4), .pc_inc(pc_inc4), .halted(halted4), .err(err4),
    .instr_cnt(instr_cnt4)
  );

  // Expected output bundle: {wr_sel, rd_sel, mem_req, mem_we, alu_add, pc_inc, halted}
  function automatic logic [12:0] pk(input int wr, input int rd, input int req,
                                     input int we, input int add, input int inc,
                                     input int h);
    return {4'(wr), 4'(rd), 1'(req), 1'(we), 1'(add), 1'(inc), 1'(h)};
  endfunction

  localparam logic [12:0] c_ZERO  = 13'd0;
  localparam logic [12:0] c_FAR   = {4'd6, 4'd9, 5'b00000};
  localparam logic [12:0] c_FACK  = {4'd8, 4'd10, 5'b10010};
  localparam logic [12:0] c_HALT  = {4'd0, 4'd0, 5'b00001};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic co(input string tag, input logic [12:0] e);
    chk(tag, {19'd0, wr_sel, rd_sel, mem_req, mem_we, alu_add, pc_inc, halted},
        {19'd0, e});
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
`ifdef ILLEGAL_TRAP_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rstn = 1'b0; start = 1'b0; ir_in = 8'h00; mem_ack = 1'b0;
    nxt(); nxt(); #1;
    co("reset_outs", c_ZERO);
    chk("reset_cnt", 32'(instr_cnt), 0);
    chk("reset_err", {31'd0, err}, 0);

    start = 1'b1; nxt(); #1;
    co("start_in_reset", c_ZERO);
    start = 1'b0; rstn = 1'b1;
    nxt(); #1;
    co("idle_no_start", c_ZERO);

    // NOP with zero-wait fetch; mem_ack high in F_AR is ignored
    start = 1'b1; nxt(); start = 1'b0; mem_ack = 1'b1; ir_in = 8'h00; #1;
    co("nop_f_ar", c_FAR);
    nxt(); #1; co("nop_f_mem", c_FACK);
    nxt(); #1; co("nop_decode", c_ZERO);
    chk("nop_cnt_pre", 32'(instr_cnt), 0);
    nxt(); #1; co("nop_next_f_ar", c_FAR);
    ecnt = 1; chk("nop_cnt", 32'(instr_cnt), ecnt);

    // LOAD with three wait cycles in X_MEM
    ir_in = 8'h01;
    nxt(); #1; co("load_f_mem", c_FACK);
    nxt(); mem_ack = 1'b0; #1; co("load_decode", c_ZERO);
    nxt(); #1; co("load_x_ar", pk(6, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      nxt(); #1; co("load_x_mem_wait", pk(0, 0, 1, 0, 0, 0, 0));
    end
    nxt(); mem_ack = 1'b1; #1; co("load_x_mem_ack", pk(7, 10, 1, 0, 0, 0, 0));
    nxt(); #1; co("load_next_f_ar", c_FAR);
    ecnt++; chk("load_cnt", 32'(instr_cnt), ecnt);

    // MOV R2
    ir_in = 8'h23;
    nxt(); #1; co("mov_f_mem", c_FACK);
    nxt(); #1; co("mov_decode", c_ZERO);
    nxt(); #1; co("mov_x_reg", pk(2, 7, 0, 0, 0, 0, 0));
    nxt(); #1; co("mov_next_f_ar", c_FAR);
    ecnt++; chk("mov_cnt", 32'(instr_cnt), ecnt);

    // ADD
    ir_in = 8'h15;
    nxt(); #1; co("add_f_mem", c_FACK);
    nxt(); #1; co("add_decode", c_ZERO);
    nxt(); #1; co("add_x_reg", pk(7, 11, 0, 0, 1, 0, 0));
    nxt(); #1; co("add_next_f_ar", c_FAR);
    ecnt++; chk("add_cnt", 32'(instr_cnt), ecnt);

    // MOV with register field 7: illegal
    ir_in = 8'h73;
    nxt(); #1; co("ill_f_mem", c_FACK);
    nxt(); #1; co("ill_decode", c_ZERO);
    nxt(); #1;
`ifdef ILLEGAL_TRAP_EN
    co("ill_trap_halt", c_HALT);
    chk("ill_err", {31'd0, err}, 1);
    chk("ill_cnt_kept", 32'(instr_cnt), ecnt);
    start = 1'b1; nxt(); start = 1'b0; #1;
    co("ill_resume_f_ar", c_FAR);
`else
    co("ill_as_nop_f_ar", c_FAR);
    ecnt++;
`endif
    chk("ill_err_after", {31'd0, err}, {31'd0, exp_err});
    chk("ill_cnt_after", 32'(instr_cnt), ecnt);

    // HALT instruction; start during F_MEM must be ignored
    ir_in = 8'h07;
    nxt(); mem_ack = 1'b0; start = 1'b1; #1;
    co("halt_f_mem_wait", pk(0, 0, 1, 0, 0, 0, 0));
    nxt(); mem_ack = 1'b1; #1; co("halt_f_mem_start_ign", c_FACK);
    nxt(); start = 1'b0; #1; co("halt_decode", c_ZERO);
    nxt(); #1; co("halt_state", c_HALT);
    ecnt++; chk("halt_cnt", 32'(instr_cnt), ecnt);
    nxt(); #1; co("halt_stay", c_HALT);
    start = 1'b1; nxt(); start = 1'b0; #1;
    co("halt_resume_f_ar", c_FAR);
    chk("halt_resume_cnt", 32'(instr_cnt), ecnt);
    chk("halt_resume_err", {31'd0, err}, {31'd0, exp_err});

    // STORE, reset asserted mid X_MEM
    ir_in = 8'h02;
    nxt(); #1; co("store_f_mem", c_FACK);
    nxt(); mem_ack = 1'b0; #1; co("store_decode", c_ZERO);
    nxt(); #1; co("store_x_ar", pk(6, 1, 0, 0, 0, 0, 0));
    nxt(); #1; co("store_x_mem", pk(0, 7, 1, 1, 0, 0, 0));
    rstn = 1'b0; #1;
    co("store_async_reset", c_ZERO);
    chk("store_reset_cnt", 32'(instr_cnt), 0);
    chk("store_reset_err", {31'd0, err}, 0);
    mem_ack = 1'b1; #1; rstn = 1'b1;
    nxt(); #1; co("late_ack_ignored", c_ZERO);
    chk("late_ack_cnt", 32'(instr_cnt), 0);

    // 16 NOPs: 4-bit counter wraps to 0
    ir_in = 8'h00;
    start = 1'b1; nxt(); start = 1'b0; #1;
    co("wrap_f_ar", c_FAR);
    repeat (45) nxt();
    #1;
    chk("wrap_cnt4_15", 32'(instr_cnt4), 15);
    chk("wrap_cnt16_15", 32'(instr_cnt), 15);
    repeat (3) nxt();
    #1;
    chk("wrap_cnt4_0", 32'(instr_cnt4), 0);
    chk("wrap_cnt16_16", 32'(instr_cnt), 16);
    chk("wrap_err4", {31'd0, err4}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
